// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, interrupt vector.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cp0_pkg;

  // CP0 register numbers (instruction rd field)
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // SR.IM and Cause.IP share the same bit range
  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Interrupt entry vector, also used by next-PC selection
  localparam logic [31:0] INT_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky pending flag raised when Count matches a non-zero Compare.
// Latency: pending sets on the edge where Count==Compare; Count counts every cycle.
// Backpressure: none; MTC0 writes always take effect, a Compare write clears pending.
// Ports: clk, rst_n (sync, active-low), we/sel/din (MTC0 access), count, compare, pend.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend
);

  logic count_wr;
  logic compare_wr;

  assign count_wr   = we && (sel == CP0_COUNT);
  assign compare_wr = we && (sel == CP0_COMPARE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      compare <= '0;
      pend    <= 1'b0;
    end else begin
      // A loaded value holds for this edge; counting resumes on the next one.
      if (count_wr) count <= din;
      else          count <= count + 32'd1;

      // Compare write acknowledges the timer interrupt, even if a match occurs now.
      if (compare_wr) begin
        compare <= din;
        pend    <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0: SR/Cause/EPC/PRId, interrupt request and ERET return address for next-PC.
// Latency: hwint sampled into IP with one cycle delay; intreq is combinational from registers; reads combinational.
// Backpressure: none; exl_set/exl_clr/MTC0 are accepted every cycle.
// Ports: clk, rst_n (sync, active-low), pc, din, sel, we, exl_set, exl_clr, hwint -> intreq, epc, dout.
// Optional: define CP0_TIMER_EN to add Count (reg 9) / Compare (reg 11) and the timer interrupt on IP[15].
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] din,
  input  logic [4:0]  sel,
  input  logic        we,
  input  logic        exl_set,
  input  logic        exl_clr,
  input  logic [5:0]  hwint,
  output logic        intreq,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  logic [5:0]  im_q;
  logic [5:0]  ip_q;
  logic        exl_q;
  logic        ie_q;
  logic [29:0] epc_q;
  logic        timer_pend;
  logic [5:0]  ip_eff;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic        sr_wr;
  logic        epc_wr;

  assign sr_wr  = we && (sel == CP0_SR);
  assign epc_wr = we && (sel == CP0_EPC);

`ifdef CP0_TIMER_EN
  logic [31:0] count_val;
  logic [31:0] compare_val;

  cp0_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .sel     (sel),
    .din     (din),
    .count   (count_val),
    .compare (compare_val),
    .pend    (timer_pend)
  );
`else
  assign timer_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      ip_q <= hwint;

      if (sr_wr) begin
        im_q <= din[IM_HI:IM_LO];
        ie_q <= din[IE_BIT];
      end

      // Controller handshake owns EXL over software writes; entry beats exit.
      if (exl_set)      exl_q <= 1'b1;
      else if (exl_clr) exl_q <= 1'b0;
      else if (sr_wr)   exl_q <= din[EXL_BIT];

      // The interrupted pc must not be lost to a concurrent MTC0.
      if (exl_set)     epc_q <= pc[31:2];
      else if (epc_wr) epc_q <= din[31:2];
    end
  end

  // Timer pending shares IP[15] with hwint[5].
  assign ip_eff = {ip_q[5] | timer_pend, ip_q[4:0]};
  assign intreq = (|(ip_eff & im_q)) & ie_q & ~exl_q;
  assign epc    = {epc_q, 2'b00};

  always_comb begin
    sr_val                  = '0;
    sr_val[IM_HI:IM_LO]     = im_q;
    sr_val[EXL_BIT]         = exl_q;
    sr_val[IE_BIT]          = ie_q;
    cause_val               = '0;
    cause_val[IP_HI:IP_LO]  = ip_eff;
  end

  always_comb begin
    dout = '0;
    case (sel)
      CP0_SR:      dout = sr_val;
      CP0_CAUSE:   dout = cause_val;
      CP0_EPC:     dout = epc;
      CP0_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   dout = count_val;
      CP0_COMPARE: dout = compare_val;
`endif
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed steps then random MTC0/interrupt traffic against a word-level model.
// Latency: each step drives inputs, checks combinational outputs, clocks once, checks again.
// Backpressure: n/a.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] din;
  logic [4:0]  sel;
  logic        we;
  logic        exl_set;
  logic        exl_clr;
  logic [5:0]  hwint;
  logic        intreq;
  logic [31:0] epc;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cp0_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc      (pc),
    .din     (din),
    .sel     (sel),
    .we      (we),
    .exl_set (exl_set),
    .exl_clr (exl_clr),
    .hwint   (hwint),
    .intreq  (intreq),
    .epc     (epc),
    .dout    (dout)
  );

  // Reference model: architectural registers as whole 32-bit words.
  logic [31:0] m_sr;
  logic [5:0]  m_ip;
  logic [31:0] m_epc;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic        m_pend;
  logic        m_valid = 1'b0;

  function automatic logic [5:0] m_ipv();
`ifdef CP0_TIMER_EN
    return m_ip | {m_pend, 5'b0};
`else
    return m_ip;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    logic [31:0] c;
    c = {16'b0, m_ipv(), 10'b0};
    case (s)
      5'd12:   return m_sr;
      5'd13:   return c;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_0001;
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_cmp;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_intreq();
    return (|(m_ipv() & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check current-cycle view, clock, update model, check new state.
  task automatic step(input logic r, input logic w, input logic [4:0] s, input logic [31:0] d,
                      input logic es, input logic ec, input logic [5:0] h, input logic [31:0] p);
    logic [31:0] n_sr;
    logic [31:0] n_epc;
    logic [31:0] n_count;
    logic [31:0] n_cmp;
    logic        n_pend;
    rst_n = r; we = w; sel = s; din = d; exl_set = es; exl_clr = ec; hwint = h; pc = p;
    #1;
    if (m_valid) begin
      chk("pre_dout", dout, m_read(s));
      chk("pre_intreq", {31'b0, intreq}, {31'b0, m_intreq()});
    end
    @(posedge clk);
    if (!r) begin
      m_sr = 0; m_ip = 0; m_epc = 0; m_count = 0; m_cmp = 0; m_pend = 0;
      m_valid = 1'b1;
    end else begin
      n_sr = m_sr;
      if (w && s == 5'd12) n_sr = d & 32'h0000_FC03;
      if (es)      n_sr[1] = 1'b1;
      else if (ec) n_sr[1] = 1'b0;
      n_epc = m_epc;
      if (es)                   n_epc = p & ~32'h3;
      else if (w && s == 5'd14) n_epc = d & ~32'h3;
      n_count = (w && s == 5'd9) ? d : m_count + 32'd1;
      n_cmp   = (w && s == 5'd11) ? d : m_cmp;
      n_pend  = m_pend;
      if (w && s == 5'd11)                        n_pend = 1'b0;
      else if (m_count == m_cmp && m_cmp != 32'd0) n_pend = 1'b1;
      m_sr = n_sr; m_epc = n_epc; m_ip = h;
      m_count = n_count; m_cmp = n_cmp; m_pend = n_pend;
    end
    #1;
    chk("post_dout", dout, m_read(s));
    chk("post_epc", epc, m_epc);
    chk("post_intreq", {31'b0, intreq}, {31'b0, m_intreq()});
  endtask

  initial begin
    logic [4:0] rs;
    logic       seen;

    // Reset with everything hostile
    step(0, 1, 5'd12, 32'hFFFF_FFFF, 1, 0, 6'h3F, 32'hFFFF_FFFF);
    step(0, 1, 5'd12, 32'hFFFF_FFFF, 0, 1, 6'h3F, 32'hFFFF_FFFF);
    step(1, 0, 5'd12, 32'h0, 0, 0, 6'h00, 32'h0);
    chk("rst_sr", dout, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_intreq", {31'b0, intreq}, 32'h0);
    step(1, 0, 5'd15, 32'h0, 0, 0, 6'h00, 32'h0);
    chk("rst_prid", dout, 32'h0000_0001);

    // Enable IM[10]+IE, then one-cycle hwint sampling latency
    step(1, 1, 5'd12, 32'h0000_0401, 0, 0, 6'h00, 32'h0);
    chk("sr_wr", dout, 32'h0000_0401);
    step(1, 0, 5'd12, 32'h0, 0, 0, 6'h01, 32'h0);
    chk("irq_latency", {31'b0, intreq}, 32'h1);
    step(1, 0, 5'd12, 32'h0, 0, 0, 6'h02, 32'h0);
    chk("irq_masked", {31'b0, intreq}, 32'h0);

    // Entry / exit
    step(1, 0, 5'd12, 32'h0, 0, 0, 6'h01, 32'h0);
    chk("irq_again", {31'b0, intreq}, 32'h1);
    step(1, 0, 5'd12, 32'h0, 1, 0, 6'h01, 32'h0000_3010);
    chk("entry_epc", epc, 32'h0000_3010);
    chk("entry_sr", dout, 32'h0000_0403);
    chk("entry_intreq", {31'b0, intreq}, 32'h0);
    step(1, 0, 5'd12, 32'h0, 0, 1, 6'h01, 32'h0);
    chk("eret_intreq", {31'b0, intreq}, 32'h1);

    // Collisions
    step(1, 1, 5'd14, 32'h0000_5000, 1, 1, 6'h01, 32'h0000_3020);
    chk("coll_epc", epc, 32'h0000_3020);
    step(1, 0, 5'd12, 32'h0, 0, 0, 6'h01, 32'h0);
    chk("coll_exl", dout, 32'h0000_0403);
    step(1, 1, 5'd12, 32'h0000_0002, 0, 1, 6'h01, 32'h0);
    chk("sr_wr_clr", dout, 32'h0);

    // Alignment, read-only Cause, unimplemented register
    step(1, 1, 5'd14, 32'h0000_3007, 0, 0, 6'h01, 32'h0);
    chk("epc_align", epc, 32'h0000_3004);
    step(1, 1, 5'd13, 32'hFFFF_FFFF, 0, 0, 6'h01, 32'h0);
    chk("cause_ro", dout, 32'h0000_0400);
    step(1, 0, 5'd3, 32'h0, 0, 0, 6'h01, 32'h0);
    chk("unimpl_rd", dout, 32'h0);

`ifdef CP0_TIMER_EN
    step(1, 1, 5'd12, 32'h0000_8001, 0, 0, 6'h00, 32'h0);
    step(1, 1, 5'd11, 32'd5, 0, 0, 6'h00, 32'h0);
    step(1, 1, 5'd9, 32'd0, 0, 0, 6'h00, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1, 0, 5'd9, 32'h0, 0, 0, 6'h00, 32'h0);
      seen = intreq;
    end
    chk("timer_irq", {31'b0, seen}, 32'h1);
    step(1, 1, 5'd11, 32'd0, 0, 0, 6'h00, 32'h0);
    chk("timer_clr", {31'b0, intreq}, 32'h0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: rs = 5'd12;
        1: rs = 5'd13;
        2: rs = 5'd14;
        3: rs = 5'd15;
        4: rs = 5'd9;
        5: rs = 5'd11;
        default: rs = 5'($urandom_range(0, 31));
      endcase
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 2) == 0),
           rs,
           $urandom,
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0),
           6'($urandom),
           $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor-0 block supplying the next-PC stage with the interrupt request (selects vector 0x0000_4180) and the exception return address (used on ERET).
- Holds the SR, Cause, EPC and PRId registers.
- Serves MFC0/MTC0 accesses from the datapath.
- Sits beside the PC register, upstream of next-PC selection; the controller handshakes interrupt entry and exit through it.

Parameters:
PRID, 32'h0000_0001, constant value returned when reading register 15.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
pc  in  32  resume address captured into EPC on interrupt entry
din  in  32  MTC0 write data (GPR[rt])
sel  in  5  CP0 register number (instruction rd field)
we  in  1  MTC0 write enable
exl_set  in  1  controller accepts interrupt this cycle
exl_clr  in  1  controller executes ERET this cycle
hwint  in  6  external hardware interrupt lines, level-sensitive
intreq  out  1  interrupt request to controller / next-PC select
epc  out  32  current EPC value, to next-PC
dout  out  32  MFC0 read data

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is synchronous and active-low. rst_n=0 at an edge forces SR=0, Cause=0, EPC=0, overriding all other inputs. Outputs after reset: intreq=0, epc=0, dout = f(sel) per read map. Reset mid-interrupt clears EXL; no state survives.
- SR (reg 12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause (reg 13): IP=[15:10], ExcCode=[6:2] always 0 (interrupt only); all other bits 0.
- Cause writes: software-read-only; MTC0 to 13 is ignored.
- IP register: IP <= hwint every cycle. hwint change at edge n appears in IP after edge n and drives intreq during cycle n+1, a one-cycle sampling latency.
- intreq is combinational from registers: intreq = |(IP & IM) & IE & ~EXL.
- EPC (reg 14): on exl_set, EPC <= {pc[31:2],2'b00}. On MTC0 to 14, EPC <= {din[31:2],2'b00}. epc output = EPC.
- Interrupt entry (exl_set=1): EXL <= 1, so intreq drops in the next cycle. The controller must only assert exl_set while intreq=1; exl_set with intreq=0 still sets EXL and captures EPC, with no error flagged.
- Interrupt exit (exl_clr=1): EXL <= 0. If a pending unmasked IP remains, intreq re-asserts the cycle after the clearing edge.
- Simultaneous events:
  - exl_set with exl_clr: exl_set wins (EXL=1).
  - MTC0 to SR with exl_set or exl_clr: IM and IE take din; EXL follows exl_set/exl_clr, not din[1].
  - MTC0 to EPC with exl_set: captured pc wins.
- MTC0 to SR with neither exl_set nor exl_clr: IM<=din[15:10], EXL<=din[1], IE<=din[0].
- Read map (combinational): sel 12 SR, 13 Cause, 14 EPC, 15 PRID; any other sel returns 0. A read in the same cycle as a write returns the old value.
- We to unimplemented sel: no effect.

Optional Feature:
- CP0_TIMER_EN defined:
  - Adds Count (reg 9) and Compare (reg 11).
  - Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF->0. MTC0 to 9 loads din, and incrementing resumes the following cycle.
  - When Count==Compare and Compare!=0, a sticky timer-pending bit sets. It is ORed into IP[15] alongside hwint[5], and clears on any MTC0 to 11.
  - Reset: Count=0, Compare=0, pending=0.
- CP0_TIMER_EN undefined: regs 9/11 read 0, writes are ignored, and IP[15] = hwint[5] only.

Decomposition:
- Package cp0_pkg: register indices (CP0_COUNT=9, CP0_COMPARE=11, CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15); bit positions/ranges IM_HI=15, IM_LO=10, EXL_BIT=1, IE_BIT=0; IP range; interrupt vector constant 32'h0000_4180 shared with next-PC.
- One sub-module, cp0_timer (Count/Compare/pending logic), instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset: rst_n=0 for 2 cycles with hwint=6'h3F, we=1, din=32'hFFFF_FFFF, sel=12 -> after release SR=0, EPC=0, intreq=0, dout(sel=15)=32'h0000_0001.
- Enable/latency: MTC0 sel=12 din=32'h0000_0401 (IM[10], IE), then hwint=6'h01 at edge n -> intreq=1 in cycle n+1; hwint=6'h02 instead -> intreq stays 0.
- Entry/exit: intreq=1, pc=32'h0000_3010, pulse exl_set -> EPC=32'h0000_3010, EXL=1, intreq=0 next cycle; pulse exl_clr with hwint still 6'h01 -> intreq=1 one cycle later.
- Collisions: same cycle exl_set=1, exl_clr=1, we=1 sel=14 din=32'h0000_5000, pc=32'h0000_3020 -> EXL=1, EPC=32'h0000_3020. MTC0 SR din=32'h0000_0002 with exl_clr -> EXL=0.
- Masking/alignment: MTC0 sel=14 din=32'h0000_3007 -> epc=32'h0000_3004; MTC0 sel=13 din=32'hFFFF_FFFF -> Cause unchanged; read sel=3 -> 0.
- Timer (CP0_TIMER_EN): Compare=5, Count=0, IM[15]=IE=1 -> intreq=1 after Count reaches 5; MTC0 Compare=0 -> pending cleared, intreq=0.
